lsb_embed_ctrl: RTL

LSB_EMBED_CTRL -- requirements
Module: lsb_embed_ctrl

---
 rtl/lsb_embed_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lsb_embed_ctrl.sv
// LSB steganography embed controller: hides each message byte (LSB first) in the
// low bits of eight cover pixels. Optional build macro LSB_XOR_KEY_EN adds a rotating XOR key.
module lsb_embed_ctrl #(
    parameter int LEN_W = 11
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] msg_len,
`ifdef LSB_XOR_KEY_EN
    input  logic [7:0]       key,
`endif
    input  logic [7:0]       msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [7:0]       pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Streams: a beat transfers on a rising edge where valid && ready are both high;
    // a producer holds valid and data stable until then, and ready never depends on
    // the same stream's valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EMBED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             kill;
    logic             msg_hs;
    logic             pix_hs;
    logic             last_bit;
    logic             last_byte;
    logic             unused_pix_lsb;

`ifdef LSB_XOR_KEY_EN
    logic [7:0] key_q;
`endif

    assign unused_pix_lsb = pix_data[0];

    // Abort only matters once a job is underway; it also cancels any handshake this cycle.
    assign kill      = abort && (state_q != S_IDLE);
    assign msg_ready = (state_q == S_LOAD);
    assign pix_ready = (state_q == S_EMBED) && (!out_valid || out_ready);
    assign msg_hs    = msg_valid && msg_ready && !kill;
    assign pix_hs    = pix_valid && pix_ready && !kill;
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = ((byte_cnt + LEN_W'(1)) == len_q);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (msg_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (msg_hs) begin
                    state_d = S_EMBED;
                end
            end
            S_EMBED: begin
                if (pix_hs && last_bit) begin
                    state_d = last_byte ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
            done    = 1'b0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef LSB_XOR_KEY_EN
            key_q     <= '0;
`endif
        end else begin
            state_q <= state_d;

            if ((state_q == S_IDLE) && start) begin
                len_q    <= msg_len;
                byte_cnt <= '0;
`ifdef LSB_XOR_KEY_EN
                key_q    <= key;
`endif
            end

            if (msg_hs) begin
`ifdef LSB_XOR_KEY_EN
                shift_q <= msg_data ^ key_q;
                key_q   <= {key_q[6:0], key_q[7]};
`else
                shift_q <= msg_data;
`endif
                bit_cnt <= '0;
            end

            if (pix_hs) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (last_bit) begin
                    byte_cnt <= byte_cnt + LEN_W'(1);
                end
            end

            // Single output stage: refill on a pixel beat, otherwise drain on out_ready.
            if (kill) begin
                out_valid <= 1'b0;
            end else if (pix_hs) begin
                out_data  <= {pix_data[7:1], shift_q[bit_cnt]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
